simon_rand_gen: RTL
===================

# simon_rand_gen

Parametrised pseudo-random draw generator for the Simon game, replacing the free-running 2-bit color counter. A free-running Fibonacci LFSR advances every clock. A request/valid handshake returns one OUT_W-bit value per draw after a fixed mixing delay. The generator sits between the game sequencer, which issues draws, and the color/sequence memory, which stores the returned values.

## Interface
- LFSR_W, 16: LFSR width; legal values 8, 16, 24, 32 (others: elaboration error).
- OUT_W, 2: draw width; 1 ≤ OUT_W ≤ LFSR_W; 2 gives four colors.
- SEED, 16'hACE1: reset/fallback seed, LFSR_W bits, must be nonzero.
- MIX_CYCLES, 4: extra LFSR steps between request and capture; 0 to 255.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- req  in  1  draw request; sampled only in IDLE.
- seed_load  in  1  load seed_in into LFSR this cycle.
- seed_in  in  LFSR_W  seed value.
- busy  out  1  high whenever the FSM is not in IDLE.
- rand_valid  out  1  one-cycle pulse: rand_num holds a new draw.
- rand_num  out  OUT_W  last drawn value; held until the next draw.
- lfsr_q  out  LFSR_W  current LFSR state, for debug and test.

## Operation
- LFSR: shift left one step per cycle; new LSB = XOR of the tap bits (1-indexed).
  - Taps for each width: 8: 8,6,5,4; 16: 16,15,13,4; 24: 24,23,22,17; 32: 32,22,2,1.
- LFSR priority: RST > seed_load > step.
  - seed_load loads seed_in, or SEED if seed_in == 0. The all-zero lock-up state is therefore unreachable.
- FSM states: IDLE, MIX, DRAW.
  - IDLE: on req=1, go to MIX and clear mix_cnt. If MIX_CYCLES == 0, go directly to DRAW.
  - MIX: mix_cnt increments each cycle. When mix_cnt == MIX_CYCLES-1, go to DRAW.
  - DRAW: capture rand_num <= lfsr_q[OUT_W-1:0] and pulse rand_valid, with the macro exceptions below. Go to IDLE.
- req is ignored while busy; a held req triggers a new draw on the first IDLE cycle.
- seed_load in MIX or DRAW is honored. The draw uses the reloaded-and-stepped state; FSM timing is unchanged.
- Reset values: rand_num=0, rand_valid=0, busy=0, lfsr_q=SEED, state=IDLE, mix_cnt=0, have_last=0.

## Timing
- If req is sampled at edge E (in IDLE), rand_valid is high for exactly the cycle after edge E+MIX_CYCLES+1.
  - Latency is MIX_CYCLES+1 clocks, plus retries when RAND_NO_REPEAT_EN is defined.
- busy rises after edge E and falls at the same edge that raises rand_valid.
  - A back-to-back draw is possible: req sampled in that same cycle is accepted. Throughput is one draw per MIX_CYCLES+2 cycles.
- rand_num changes only at the edge that raises rand_valid.
- RST mid-draw aborts the draw: no rand_valid, and all reset values apply on the next cycle.

## Configuration
- RAND_NO_REPEAT_EN defined:
  - In DRAW, if have_last=1 and lfsr_q[OUT_W-1:0] equals rand_num, stay in DRAW one more cycle. The LFSR steps and the comparison is retried. No pulse is issued during a retry.
  - On acceptance, capture the value and set have_last=1.
  - The first draw after reset is never rejected.
  - With OUT_W=1, outputs strictly alternate.
- RAND_NO_REPEAT_EN undefined:
  - DRAW always captures in one cycle; have_last logic is absent.
  - Consecutive repeats are allowed.

## Test plan
- Reset with defaults, RST low: lfsr_q=16'hACE1 in the first cycle, 16'h59C3 the next; rand_num=0, rand_valid=0, busy=0.
- Defaults, 1-cycle req at edge E: busy is high for 5 cycles; rand_valid pulses once after edge E+5; rand_num equals bits [1:0] of a reference-model LFSR at that edge.
- seed_load=1 with seed_in=0: next lfsr_q=16'hACE1. seed_load=1 with seed_in=16'h0001: next lfsr_q=16'h0001, then 16'h0002.
- req held high for 100 cycles with MIX_CYCLES=0: a rand_valid pulse every 2 cycles with no overlap; all 4 values appear.
- RST asserted in MIX: no rand_valid follows; outputs return to reset values the next cycle.
- RAND_NO_REPEAT_EN, OUT_W=2, 1000 draws: no two consecutive rand_num values are equal, every latency is ≥ MIX_CYCLES+1, and each pulse matches the reference model including retries.

Source files
------------

// File: rtl/simon_rand_gen_if.sv
// -----------------------------------------------------------------------------
// simon_rand_gen_if
// Draw handshake between the game sequencer (master) and the random draw
// generator (slave).
//   req        master -> slave  draw request
//   seed_load  master -> slave  load seed_in into the LFSR this cycle
//   seed_in    master -> slave  LFSR_W-bit seed (zero selects the built-in seed)
//   busy       slave -> master  generator is working on a draw
//   rand_valid slave -> master  one-cycle pulse, rand_num holds a new draw
//   rand_num   slave -> master  last drawn value, OUT_W bits
//   lfsr_q     slave -> master  current LFSR state (debug / test)
// LFSR_W and OUT_W must match the parameters of the attached simon_rand_gen.
// -----------------------------------------------------------------------------
interface simon_rand_gen_if #(
  parameter int LFSR_W = 16,
  parameter int OUT_W  = 2
);
  logic              req;
  logic              seed_load;
  logic [LFSR_W-1:0] seed_in;
  logic              busy;
  logic              rand_valid;
  logic [OUT_W-1:0]  rand_num;
  logic [LFSR_W-1:0] lfsr_q;

  modport master (
    output req, seed_load, seed_in,
    input  busy, rand_valid, rand_num, lfsr_q
  );

  modport slave (
    input  req, seed_load, seed_in,
    output busy, rand_valid, rand_num, lfsr_q
  );
endinterface

// File: rtl/simon_rand_gen.sv
// -----------------------------------------------------------------------------
// simon_rand_gen
// Pseudo-random draw generator for the Simon game. A Fibonacci LFSR steps
// every clock; each accepted request waits MIX_CYCLES extra steps and then
// captures the low OUT_W bits of the LFSR as the new draw.
//
// Ports:
//   CLK  system clock, rising edge
//   RST  synchronous active-high reset
//   bus  simon_rand_gen_if.slave (req, seed_load, seed_in, busy, rand_valid,
//        rand_num, lfsr_q)
//
// Parameters: LFSR_W (8/16/24/32), OUT_W (1..LFSR_W), SEED (nonzero),
//             MIX_CYCLES (0..255).
//
// Optional feature macro: RAND_NO_REPEAT_EN
//   When defined, a draw equal to the previous one is rejected and retried
//   one cycle later (no pulse during the retry). When undefined, every draw
//   completes in a single DRAW cycle and repeats are allowed.
// -----------------------------------------------------------------------------
module simon_rand_gen #(
  parameter int                LFSR_W     = 16,
  parameter int                OUT_W      = 2,
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
  parameter int                MIX_CYCLES = 4
) (
  input logic              CLK,
  input logic              RST,
  simon_rand_gen_if.slave  bus
);

  // Tap masks (bit n of the 1-indexed tap list is bit n-1 of the mask).
  function automatic logic [31:0] tap_mask(input int w);
    logic [31:0] m;
    case (w)
      32'sd8:  m = 32'h0000_00B8;   // 8,6,5,4
      32'sd16: m = 32'h0000_D008;   // 16,15,13,4
      32'sd24: m = 32'h00E1_0000;   // 24,23,22,17
      32'sd32: m = 32'h8020_0003;   // 32,22,2,1
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  localparam logic [31:0]       TAP_FULL = tap_mask(LFSR_W);
  localparam logic [LFSR_W-1:0] TAP_MASK = TAP_FULL[LFSR_W-1:0];
  localparam logic [7:0]        MIX_LAST = (MIX_CYCLES > 0) ? 8'(MIX_CYCLES - 1) : 8'd0;
  localparam bit                MIX_NONE = (MIX_CYCLES == 0);

  // Feedback bit is the parity of the tapped bits.
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return ^(s & TAP_MASK);
  endfunction

  // Parameter legality is enforced at elaboration.
  if (!(LFSR_W == 8 || LFSR_W == 16 || LFSR_W == 24 || LFSR_W == 32)) begin : g_bad_lfsr_w
    $error("simon_rand_gen: LFSR_W must be 8, 16, 24 or 32");
  end
  if (OUT_W < 1 || OUT_W > LFSR_W) begin : g_bad_out_w
    $error("simon_rand_gen: OUT_W must be in 1..LFSR_W");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("simon_rand_gen: SEED must be nonzero");
  end
  if (MIX_CYCLES < 0 || MIX_CYCLES > 255) begin : g_bad_mix
    $error("simon_rand_gen: MIX_CYCLES must be in 0..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DRAW = 2'd2
  } state_t;

  state_t            state_r;
  logic [7:0]        mix_cnt_r;
  logic [LFSR_W-1:0] lfsr_r;
  logic [OUT_W-1:0]  rand_num_r;
  logic              rand_valid_r;
  logic              busy_r;
  logic [LFSR_W-1:0] seed_val_s;
  logic [OUT_W-1:0]  draw_s;
  logic              reject_s;

  assign draw_s = lfsr_r[OUT_W-1:0];

`ifdef RAND_NO_REPEAT_EN
  logic have_last_r;
  // A candidate equal to the last accepted draw is rejected; never before the first draw.
  assign reject_s = have_last_r && (draw_s == rand_num_r);
`else
  assign reject_s = 1'b0;
`endif

  // Zero seed falls back to SEED so the all-zero lock-up state cannot be entered.
  always_comb begin
    seed_val_s = SEED;
    if (bus.seed_in != '0) begin
      seed_val_s = bus.seed_in;
    end else begin
      seed_val_s = SEED;
    end
  end

  // LFSR: reset > seed load > free-running step.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_r <= SEED;
    end else if (bus.seed_load) begin
      lfsr_r <= seed_val_s;
    end else begin
      lfsr_r <= {lfsr_r[LFSR_W-2:0], lfsr_fb(lfsr_r)};
    end
  end

  // Draw FSM with registered busy / rand_valid / rand_num.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= IDLE;
      mix_cnt_r    <= 8'd0;
      rand_num_r   <= '0;
      rand_valid_r <= 1'b0;
      busy_r       <= 1'b0;
`ifdef RAND_NO_REPEAT_EN
      have_last_r  <= 1'b0;
`endif
    end else begin
      rand_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req) begin
            mix_cnt_r <= 8'd0;
            busy_r    <= 1'b1;
            if (MIX_NONE) begin
              state_r <= DRAW;
            end else begin
              state_r <= MIX;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        MIX: begin
          mix_cnt_r <= mix_cnt_r + 8'd1;
          if (mix_cnt_r == MIX_LAST) begin
            state_r <= DRAW;
          end else begin
            state_r <= MIX;
          end
        end
        DRAW: begin
          if (reject_s) begin
            // Stay one more cycle; the LFSR has stepped by the next compare.
            state_r <= DRAW;
          end else begin
            rand_num_r   <= draw_s;
            rand_valid_r <= 1'b1;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
`ifdef RAND_NO_REPEAT_EN
            have_last_r  <= 1'b1;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.rand_valid = rand_valid_r;
  assign bus.rand_num   = rand_num_r;
  assign bus.lfsr_q     = lfsr_r;

endmodule
